uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ byte-stream requesters (command-response path, status/debug dump, result readback).
- Grants round-robin at packet granularity: once a requester wins, it owns the transmitter until it hands over a byte flagged last, so packets never interleave on the wire.
- Holds one byte in an output register and drives the transmitter's valid/data/ready handshake.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); IDX_W = $clog2(NUM_REQ) is derived internally.
- TIMEOUT_CYCLES, 1_000_000, idle cycles tolerated inside a locked packet before forced release (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  NUM_REQ  per-requester byte valid
- in_data  in  NUM_REQ*8  per-requester byte; requester i on bits [8i+7:8i]
- in_last  in  NUM_REQ  byte is the final byte of its packet
- in_ready  out  NUM_REQ  per-requester accept; at most one bit high
- gnt  out  NUM_REQ  one-hot current owner; all zero when unlocked
- busy  out  1  high while locked or while out_valid is high
- out_data  out  8  byte to the UART transmitter
- out_valid  out  1  byte to the UART transmitter is valid
- out_ready  in  1  transmitter idle/accept
- timeout_err  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (async, any time): state=ARB, gnt=0, rr_ptr=NUM_REQ-1, out_valid=0, out_data=0, timeout_err=0, timeout counter=0. A byte held in the output register is discarded. A UART frame already on the wire is not the arbiter's concern.
- Transfer rules:
  - Input transfer: in_valid[i] & in_ready[i].
  - Output transfer: out_valid & out_ready.
  - out_valid, once high, stays high with out_data stable until the output transfer.
- in_ready[i] = (state==LOCK) & gnt[i] & (!out_valid | out_ready). This is combinational from registered state and out_ready.
- State ARB:
  - Scan in_valid starting at index rr_ptr+1 mod NUM_REQ; the first set bit wins.
  - If a winner exists: gnt <= onehot(winner), state <= LOCK.
  - If none: remain in ARB.
  - in_ready is all zero in ARB.
- State LOCK:
  - On an input transfer: out_data <= in_data[gnt]; out_valid <= 1.
  - If in_last is set on that transfer: state <= ARB, gnt <= 0, rr_ptr <= granted index, all in the same edge.
  - An output transfer with no new input transfer clears out_valid.
- Latency (buffer empty, out_ready=1):
  - in_valid rising at cycle N -> gnt at N+1 -> input transfer at N+1 -> out_valid at N+2.
  - Minimum packet-to-packet gap is 1 ARB cycle.
- Simultaneous events:
  - A requester raising in_valid in the same cycle another releases is not seen until the next ARB cycle.
  - Output and input transfers in the same cycle: the new byte replaces the old, and out_valid stays 1.
- A granted requester dropping in_valid mid-packet keeps the lock; the arbiter waits indefinitely unless the optional feature is enabled.
- in_last on a single-byte packet: lock and release around exactly one input transfer.
- rr_ptr wraps NUM_REQ-1 -> 0.
- A requester that wins is lowest priority at the next ARB; no requester starves while others keep sending finite packets.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- When defined:
  - A 32-bit counter increments each LOCK cycle in which there is no input transfer and out_valid==0.
  - The counter clears on any input transfer and on entry to LOCK.
  - On reaching TIMEOUT_CYCLES-1: state <= ARB, gnt <= 0, rr_ptr <= granted index, timeout_err pulses high for 1 cycle. The partial packet is truncated with no filler bytes.
- When undefined: no counter is built, timeout_err is tied 0, and the lock is held until in_last.

Test Plan:
- Requester 2 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), out_ready=1:
  - gnt=4'b0100 one cycle after in_valid rises.
  - out_data sequence 0x41,0x42,0x43.
  - gnt returns to 0 after the 0x43 transfer.
- All four requesters hold 2-byte packets continuously from reset: grant order 0,1,2,3,0; no interleaving of bytes across packets on out_data.
- Backpressure: out_ready held 0 for 20 cycles with out_valid=1:
  - out_data stays stable.
  - in_ready[gnt]=0 throughout.
  - On out_ready=1, the next byte is accepted the same cycle.
- Requester 1 stalls mid-packet (in_valid=0 for 50 cycles) while requester 3 is requesting:
  - gnt stays 4'b0010.
  - Requester 3 is not granted until requester 1 sends its last byte.
- Reset asserted while out_valid=1 and locked: out_valid=0 and gnt=0 immediately (asynchronously); first grant after reset goes to requester 0.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, granted requester goes silent:
  - timeout_err pulses exactly once, on the 16th idle cycle.
  - The next pending requester is granted one cycle later.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte-stream
// requesters. Grants are round-robin and held for a whole packet, so packets
// never interleave on the wire. One byte is buffered in an output register.
// Build option: define UART_ARB_TIMEOUT_EN to force-release a lock that has
// been idle for TIMEOUT_CYCLES cycles (pulses timeout_err on release).
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   in_valid,
  input  logic [NUM_REQ*8-1:0] in_data,
  input  logic [NUM_REQ-1:0]   in_last,
  output logic [NUM_REQ-1:0]   in_ready,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 busy,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [IDX_W-1:0]   owner_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [7:0]         out_data_q;
  logic               out_valid_q;

  logic               out_free;
  logic               in_fire;
  logic [7:0]         sel_data;
  logic               sel_last;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W:0]     scan_pos;
  logic               timeout_hit;

  // Output register can take a new byte when empty or being drained this cycle.
  assign out_free = ~out_valid_q | out_ready;

  // Only the current owner sees ready, and only while locked.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign in_ready[gi] = (state_q == LOCK) & gnt_q[gi] & out_free;
  end

  assign in_fire  = |(in_valid & in_ready);
  assign sel_data = in_data[{owner_q, 3'b000} +: 8];
  assign sel_last = in_last[owner_q];

  // Round-robin scan starting just after the last winner; the nearest set bit wins.
  // Iterating from the farthest position down lets the closest one overwrite.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_pos  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_pos = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (scan_pos >= (IDX_W+1)'(NUM_REQ)) begin
        scan_pos = scan_pos - (IDX_W+1)'(NUM_REQ);
      end
      if (in_valid[scan_pos[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_pos[IDX_W-1:0];
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0] idle_cnt_q;
  logic        timeout_err_q;
  logic        lock_idle;

  // A locked cycle counts as idle only when nothing moves and nothing is buffered.
  assign lock_idle   = (state_q == LOCK) & ~in_fire & ~out_valid_q;
  assign timeout_hit = lock_idle & (idle_cnt_q == 32'(TIMEOUT_CYCLES - 1));
  assign timeout_err = timeout_err_q;

  // Idle counter: held at zero in ARB (so it starts clean on entry to LOCK),
  // cleared on every accepted byte, and one-cycle error pulse on forced release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= timeout_hit;
      if (state_q == ARB || in_fire || timeout_hit) begin
        idle_cnt_q <= '0;
      end else if (lock_idle) begin
        idle_cnt_q <= idle_cnt_q + 32'd1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Arbitration FSM plus the output byte register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB;
      gnt_q       <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= IDX_W'(NUM_REQ - 1);
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // A new byte replaces a drained one in the same cycle; otherwise drain clears.
      if (in_fire) begin
        out_data_q  <= sel_data;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        ARB: begin
          if (win_found) begin
            state_q <= LOCK;
            gnt_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
            owner_q <= win_idx;
          end
        end
        LOCK: begin
          if ((in_fire && sel_last) || timeout_hit) begin
            state_q  <= ARB;
            gnt_q    <= '0;
            rr_ptr_q <= owner_q;
          end
        end
        default: begin
          state_q <= ARB;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == LOCK) | out_valid_q;

endmodule
